// File: rtl/ec_exc_ctrl.sv
// Exception arbiter and CP0 register file at the commit stage; flush/redirect registered, one cycle after commit.
// No backpressure: one instruction may commit per cycle, and flushes can issue on consecutive cycles.
module ec_exc_ctrl #(
  parameter int          HW_INT_N    = 6,
  parameter int          SYNC_STAGES = 2,
  parameter int          COUNT_DIV   = 2,
  parameter int          EX_W        = 6,
  parameter logic [31:0] EXC_VEC     = 32'hBFC0_0380
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [HW_INT_N-1:0] ext_int,
  input  logic                ec_valid,
  input  logic [EX_W-1:0]     ec_ex,
  input  logic                ec_load,
  input  logic                ec_bd,
  input  logic [31:0]         ec_pc,
  input  logic [31:0]         ec_badaddr,
  input  logic                ec_eret,
  input  logic                ec_cp0wen,
  input  logic [7:0]          ec_cp0addr,
  input  logic [31:0]         ec_wdata,
  output logic [31:0]         ec_cp0rdata,
  output logic                exc_flush,
  output logic [31:0]         exc_target,
  output logic [31:0]         cp0_epc,
  output logic                status_exl
);

  localparam logic [7:0] ADDR_BADVADDR = 8'd8  << 3;
  localparam logic [7:0] ADDR_COUNT    = 8'd9  << 3;
  localparam logic [7:0] ADDR_COMPARE  = 8'd11 << 3;
  localparam logic [7:0] ADDR_STATUS   = 8'd12 << 3;
  localparam logic [7:0] ADDR_CAUSE    = 8'd13 << 3;
  localparam logic [7:0] ADDR_EPC      = 8'd14 << 3;

  logic [HW_INT_N-1:0] sync_q [SYNC_STAGES];
  logic [5:0]  hw_ip;
  logic [7:0]  ip;
  logic [7:0]  status_im;
  logic        status_ie;
  logic        exl;
  logic        cause_bd;
  logic        cause_ti;
  logic [1:0]  cause_ip_sw;
  logic [4:0]  cause_code;
  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic [31:0] count;
  logic [31:0] compare;
  logic [31:0] count_inc;
  logic        phase;
  logic        tick;
  logic        int_req;
  logic        exc_take;
  logic        eret_take;
  logic        wr_en;
  logic [4:0]  exc_code;
  logic        bad_wr;
  logic [31:0] bad_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= ext_int;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Lines beyond HW_INT_N stay 0, so IP7 degenerates to the timer alone.
  always_comb begin
    hw_ip = '0;
    hw_ip[HW_INT_N-1:0] = sync_q[SYNC_STAGES-1];
  end

  assign ip        = {hw_ip[5] | cause_ti, hw_ip[4:0], cause_ip_sw};
  assign int_req   = status_ie & ~exl & (|(ip & status_im));
  assign exc_take  = ec_valid & ~exl & (int_req | (|ec_ex));
  assign eret_take = ec_valid & ec_eret & ~exc_take;
  // An instruction carrying any exception flag never commits its CP0 write.
  assign wr_en     = ec_valid & ec_cp0wen & ~(|ec_ex) & ~exc_take;
  assign tick      = (COUNT_DIV == 1) ? 1'b1 : phase;
  assign count_inc = count + 32'd1;

  always_comb begin
    exc_code = 5'h00;
    bad_wr   = 1'b0;
    bad_val  = ec_badaddr;
    if (int_req) begin
      exc_code = 5'h00;
    end else if (ec_ex[5]) begin
      exc_code = 5'h04;
      bad_wr   = 1'b1;
      bad_val  = ec_pc;
    end else if (ec_ex[4]) begin
      exc_code = 5'h0a;
    end else if (ec_ex[3]) begin
      exc_code = 5'h0c;
    end else if (ec_ex[2]) begin
      exc_code = 5'h09;
    end else if (ec_ex[1]) begin
      exc_code = 5'h08;
    end else if (ec_ex[0]) begin
      exc_code = ec_load ? 5'h04 : 5'h05;
      bad_wr   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase    <= 1'b0;
      count    <= '0;
      compare  <= '0;
      cause_ti <= 1'b0;
    end else begin
      phase <= ~phase;
      if (wr_en && ec_cp0addr == ADDR_COUNT) count <= ec_wdata;
      else if (tick) count <= count_inc;
      // A Compare write always wins over a coincident match.
      if (wr_en && ec_cp0addr == ADDR_COMPARE) begin
        compare  <= ec_wdata;
        cause_ti <= 1'b0;
      end else if (tick && !(wr_en && ec_cp0addr == ADDR_COUNT) && count_inc == compare) begin
        cause_ti <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status_im   <= '0;
      status_ie   <= 1'b0;
      exl         <= 1'b0;
      cause_bd    <= 1'b0;
      cause_ip_sw <= '0;
      cause_code  <= '0;
      epc         <= '0;
      badvaddr    <= '0;
      exc_flush   <= 1'b0;
      exc_target  <= '0;
    end else begin
      exc_flush <= exc_take | eret_take;
      if (wr_en) begin
        case (ec_cp0addr)
          ADDR_STATUS: begin
            status_im <= ec_wdata[15:8];
            exl       <= ec_wdata[1];
            status_ie <= ec_wdata[0];
          end
          ADDR_CAUSE: cause_ip_sw <= ec_wdata[9:8];
          ADDR_EPC:   epc <= ec_wdata;
          default: ;
        endcase
      end
      if (exc_take) begin
        exl        <= 1'b1;
        cause_code <= exc_code;
        cause_bd   <= ec_bd;
        epc        <= ec_bd ? ec_pc - 32'd4 : ec_pc;
        exc_target <= EXC_VEC;
        if (bad_wr) badvaddr <= bad_val;
      end else if (eret_take) begin
        exl        <= 1'b0;
        exc_target <= epc;
      end
    end
  end

  always_comb begin
    ec_cp0rdata = '0;
    case (ec_cp0addr)
      ADDR_BADVADDR: ec_cp0rdata = badvaddr;
      ADDR_COUNT:    ec_cp0rdata = count;
      ADDR_COMPARE:  ec_cp0rdata = compare;
      ADDR_STATUS:   ec_cp0rdata = {9'b0, 1'b1, 6'b0, status_im, 6'b0, exl, status_ie};
      ADDR_CAUSE:    ec_cp0rdata = {cause_bd, cause_ti, 14'b0, ip, 1'b0, cause_code, 2'b0};
      ADDR_EPC:      ec_cp0rdata = epc;
      default:       ec_cp0rdata = '0;
    endcase
  end

  assign cp0_epc    = epc;
  assign status_exl = exl;

endmodule

// File: tb/tb_ec_exc_ctrl.sv
// Directed bench for ec_exc_ctrl with default parameters (6 lines, 2 sync stages, Count every 2 cycles).
module tb_ec_exc_ctrl;

  localparam logic [7:0] A_BADV = 8'h40;
  localparam logic [7:0] A_CNT  = 8'h48;
  localparam logic [7:0] A_CMP  = 8'h58;
  localparam logic [7:0] A_STAT = 8'h60;
  localparam logic [7:0] A_CAUS = 8'h68;
  localparam logic [7:0] A_EPC  = 8'h70;
  localparam logic [31:0] VEC   = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  ext_int;
  logic        ec_valid;
  logic [5:0]  ec_ex;
  logic        ec_load;
  logic        ec_bd;
  logic [31:0] ec_pc;
  logic [31:0] ec_badaddr;
  logic        ec_eret;
  logic        ec_cp0wen;
  logic [7:0]  ec_cp0addr;
  logic [31:0] ec_wdata;
  logic [31:0] ec_cp0rdata;
  logic        exc_flush;
  logic [31:0] exc_target;
  logic [31:0] cp0_epc;
  logic        status_exl;

  int tests = 0;
  int fails = 0;

  ec_exc_ctrl dut (
    .clk(clk), .reset(reset), .ext_int(ext_int), .ec_valid(ec_valid), .ec_ex(ec_ex),
    .ec_load(ec_load), .ec_bd(ec_bd), .ec_pc(ec_pc), .ec_badaddr(ec_badaddr),
    .ec_eret(ec_eret), .ec_cp0wen(ec_cp0wen), .ec_cp0addr(ec_cp0addr), .ec_wdata(ec_wdata),
    .ec_cp0rdata(ec_cp0rdata), .exc_flush(exc_flush), .exc_target(exc_target),
    .cp0_epc(cp0_epc), .status_exl(status_exl)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    ec_cp0addr = addr;
    #1;
    check(tag, ec_cp0rdata, exp);
  endtask

  task automatic mtc0(input logic [7:0] addr, input logic [31:0] data);
    ec_valid = 1'b1; ec_cp0wen = 1'b1; ec_cp0addr = addr; ec_wdata = data;
    step();
    ec_valid = 1'b0; ec_cp0wen = 1'b0;
  endtask

  task automatic eret_only();
    ec_valid = 1'b1; ec_eret = 1'b1;
    step();
    ec_valid = 1'b0; ec_eret = 1'b0;
  endtask

  initial begin
    logic found;
    reset = 1'b1; ext_int = '0; ec_valid = 1'b0; ec_ex = '0; ec_load = 1'b0; ec_bd = 1'b0;
    ec_pc = '0; ec_badaddr = '0; ec_eret = 1'b0; ec_cp0wen = 1'b0; ec_cp0addr = '0; ec_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state and Count prescaler
    chk_reg("rst_status", A_STAT, 32'h0040_0000);
    chk_reg("rst_count", A_CNT, 32'h0);
    check("rst_flush", exc_flush, 1'b0);
    check("rst_target", exc_target, 32'h0);
    check("rst_epc", cp0_epc, 32'h0);
    step();
    step();
    chk_reg("count_after2", A_CNT, 32'h1);

    // Syscall in a delay slot
    ec_valid = 1'b1; ec_ex = 6'b000010; ec_pc = 32'h8000_1000; ec_bd = 1'b1;
    step();
    ec_valid = 1'b0; ec_ex = '0; ec_bd = 1'b0;
    check("sys_flush", exc_flush, 1'b1);
    check("sys_target", exc_target, VEC);
    check("sys_epc", cp0_epc, 32'h8000_0FFC);
    check("sys_exl", status_exl, 1'b1);
    chk_reg("sys_cause", A_CAUS, 32'h8000_0020);
    step();
    check("sys_pulse_end", exc_flush, 1'b0);

    // External interrupt through the synchroniser
    mtc0(A_STAT, 32'h0000_0401);
    chk_reg("int_status", A_STAT, 32'h0040_0401);
    ext_int = 6'b000001;
    step();
    chk_reg("int_sync1", A_CAUS, 32'h8000_0020);
    step();
    chk_reg("int_sync2", A_CAUS, 32'h8000_0420);
    ec_valid = 1'b1; ec_pc = 32'h8000_3000;
    step();
    ec_valid = 1'b0;
    check("int_flush", exc_flush, 1'b1);
    check("int_target", exc_target, VEC);
    check("int_epc", cp0_epc, 32'h8000_3000);
    chk_reg("int_cause", A_CAUS, 32'h0000_0400);
    ext_int = '0;
    ec_valid = 1'b1; ec_ex = 6'b000100; ec_pc = 32'h8000_4000;
    step();
    ec_valid = 1'b0; ec_ex = '0;
    check("exl_block_flush", exc_flush, 1'b0);
    check("exl_block_epc", cp0_epc, 32'h8000_3000);

    // Count/Compare timer
    mtc0(A_CNT, 32'h0);
    mtc0(A_CMP, 32'h5);
    ec_cp0addr = A_CAUS;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (ec_cp0rdata[30]) found = 1'b1;
    end
    check("ti_seen", found, 1'b1);
    chk_reg("ti_cause", A_CAUS, 32'h4000_8000);
    chk_reg("ti_count", A_CNT, 32'h5);
    mtc0(A_CMP, 32'd100);
    chk_reg("ti_clear", A_CAUS, 32'h0000_0000);

    // ERET and ERET colliding with overflow
    mtc0(A_EPC, 32'h8000_2000);
    eret_only();
    check("eret_flush", exc_flush, 1'b1);
    check("eret_target", exc_target, 32'h8000_2000);
    check("eret_exl", status_exl, 1'b0);
    ec_valid = 1'b1; ec_eret = 1'b1; ec_ex = 6'b001000; ec_pc = 32'h8000_5000;
    step();
    ec_valid = 1'b0; ec_eret = 1'b0; ec_ex = '0;
    check("ov_flush", exc_flush, 1'b1);
    check("ov_target", exc_target, VEC);
    check("ov_exl", status_exl, 1'b1);
    check("ov_epc", cp0_epc, 32'h8000_5000);
    chk_reg("ov_cause", A_CAUS, 32'h0000_0030);

    // MTC0 Status suppressed by RI
    eret_only();
    ec_valid = 1'b1; ec_cp0wen = 1'b1; ec_cp0addr = A_STAT; ec_wdata = 32'h0;
    ec_ex = 6'b010000; ec_pc = 32'h8000_6000;
    step();
    ec_valid = 1'b0; ec_cp0wen = 1'b0; ec_ex = '0;
    chk_reg("ri_status", A_STAT, 32'h0040_0403);
    chk_reg("ri_cause", A_CAUS, 32'h0000_0028);

    // Software IP bits
    mtc0(A_CAUS, 32'h0000_0300);
    chk_reg("sw_ip", A_CAUS, 32'h0000_0328);

    // Store address error
    eret_only();
    ec_valid = 1'b1; ec_ex = 6'b000001; ec_load = 1'b0; ec_badaddr = 32'h0000_1003;
    ec_pc = 32'h8000_7000;
    step();
    ec_valid = 1'b0; ec_ex = '0;
    check("ades_flush", exc_flush, 1'b1);
    chk_reg("ades_cause", A_CAUS, 32'h0000_0314);
    chk_reg("ades_badv", A_BADV, 32'h0000_1003);

    // Back-to-back flushes: ERET then Sys on the next cycle
    ec_valid = 1'b1; ec_eret = 1'b1;
    step();
    check("b2b_flush1", exc_flush, 1'b1);
    check("b2b_target1", exc_target, 32'h8000_7000);
    ec_eret = 1'b0; ec_ex = 6'b000010; ec_pc = 32'h8000_8000;
    step();
    ec_valid = 1'b0; ec_ex = '0;
    check("b2b_flush2", exc_flush, 1'b1);
    check("b2b_target2", exc_target, VEC);

    // Reset while the flush pulse is high
    reset = 1'b1;
    step();
    check("rst_mid_flush", exc_flush, 1'b0);
    check("rst_mid_target", exc_target, 32'h0);
    chk_reg("rst_mid_status", A_STAT, 32'h0040_0000);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
